// File: rtl/fifo_sync_flags_if.sv
// rtl/fifo_sync_flags_if.sv - producer/consumer and status bundle for fifo_sync_flags
interface fifo_sync_flags_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;
  logic                  clr_err;

  modport master (
    output flush, wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_flags.sv
// rtl/fifo_sync_flags.sv - single-clock FIFO with registered or FWFT read, threshold flags and sticky errors
module fifo_sync_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  parameter int AFULL_TH   = DEPTH - 2,
  parameter int AEMPTY_TH  = 2
) (
  input logic              clk,
  input logic              rst,
  fifo_sync_flags_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if (DATA_WIDTH < 1 || DEPTH < 2 || (FWFT != 0 && FWFT != 1) ||
      AFULL_TH < 1 || AFULL_TH > DEPTH || AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_param_check
    $fatal(1, "fifo_sync_flags: parameter out of range");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full, empty, do_write, do_read;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  always_comb begin
    do_write    = bus.wr_en && !full && !bus.flush;
    do_read     = bus.rd_en && !empty && !bus.flush;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    // A set condition beats clr_err; flush suppresses new errors but keeps old ones.
    overflow_d  = (bus.wr_en && full && !bus.flush) || (overflow_q && !bus.clr_err);
    underflow_d = (bus.rd_en && empty && !bus.flush) || (underflow_q && !bus.clr_err);

    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      rd_valid_d = do_read;
      if (do_write) begin
        wptr_d = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
      end
      if (do_read) begin
        rptr_d    = (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + AW'(1);
        rd_data_d = mem_q[rptr_q];
      end
      if (do_write && !do_read) begin
        count_d = count_q + CW'(1);
      end else if (!do_write && do_read) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[wptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // In FWFT mode the head word is presented straight from storage; zero while empty.
  assign bus.rd_data      = (FWFT != 0) ? (empty ? '0 : mem_q[rptr_q]) : rd_data_q;
  assign bus.rd_valid     = (FWFT != 0) ? !empty : rd_valid_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(AFULL_TH));
  assign bus.almost_empty = (count_q <= CW'(AEMPTY_TH));
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb/tb_fifo_sync_flags.sv - three FIFO configurations driven in lockstep against a queue model
module tb_fifo_sync_flags;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] wr_data = '0;

  always #5 clk = ~clk;

  fifo_sync_flags_if #(.DATA_WIDTH(8), .DEPTH(16)) ifa ();
  fifo_sync_flags_if #(.DATA_WIDTH(8), .DEPTH(5))  ifb ();
  fifo_sync_flags_if #(.DATA_WIDTH(8), .DEPTH(6))  ifc ();

  fifo_sync_flags #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0), .AFULL_TH(14), .AEMPTY_TH(2))
    u_a (.clk(clk), .rst(rst), .bus(ifa));
  fifo_sync_flags #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0), .AFULL_TH(4), .AEMPTY_TH(1))
    u_b (.clk(clk), .rst(rst), .bus(ifb));
  fifo_sync_flags #(.DATA_WIDTH(8), .DEPTH(6), .FWFT(1), .AFULL_TH(5), .AEMPTY_TH(1))
    u_c (.clk(clk), .rst(rst), .bus(ifc));

  assign ifa.flush = flush;  assign ifa.wr_en = wr_en;  assign ifa.wr_data = wr_data;
  assign ifa.rd_en = rd_en;  assign ifa.clr_err = clr_err;
  assign ifb.flush = flush;  assign ifb.wr_en = wr_en;  assign ifb.wr_data = wr_data;
  assign ifb.rd_en = rd_en;  assign ifb.clr_err = clr_err;
  assign ifc.flush = flush;  assign ifc.wr_en = wr_en;  assign ifc.wr_data = wr_data;
  assign ifc.rd_en = rd_en;  assign ifc.clr_err = clr_err;

  logic [2:0][7:0] o_rd_data, o_count;
  logic [2:0]      o_rdv, o_full, o_empty, o_af, o_ae, o_ovf, o_udf;
  assign o_rd_data = {ifc.rd_data, ifb.rd_data, ifa.rd_data};
  assign o_count   = {8'(ifc.count), 8'(ifb.count), 8'(ifa.count)};
  assign o_rdv     = {ifc.rd_valid, ifb.rd_valid, ifa.rd_valid};
  assign o_full    = {ifc.full, ifb.full, ifa.full};
  assign o_empty   = {ifc.empty, ifb.empty, ifa.empty};
  assign o_af      = {ifc.almost_full, ifb.almost_full, ifa.almost_full};
  assign o_ae      = {ifc.almost_empty, ifb.almost_empty, ifa.almost_empty};
  assign o_ovf     = {ifc.overflow, ifb.overflow, ifa.overflow};
  assign o_udf     = {ifc.underflow, ifb.underflow, ifa.underflow};

  int dep  [3] = '{16, 5, 6};
  int fwft [3] = '{0, 0, 1};
  int aft  [3] = '{14, 4, 5};
  int aet  [3] = '{2, 1, 1};

  logic [7:0] mq [3][$];
  logic [7:0] m_rdq [3];
  bit         m_rdv [3];
  bit         m_ovf [3];
  bit         m_udf [3];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int  sz;
      bit  fl, em;
      sz = mq[k].size();
      fl = (sz == dep[k]);
      em = (sz == 0);
      if (rst) begin
        mq[k].delete();
        m_rdq[k] = '0; m_rdv[k] = 0; m_ovf[k] = 0; m_udf[k] = 0;
      end else if (flush) begin
        mq[k].delete();
        m_rdv[k] = 0;
        m_ovf[k] = m_ovf[k] && !clr_err;
        m_udf[k] = m_udf[k] && !clr_err;
      end else begin
        m_ovf[k] = (wr_en && fl) || (m_ovf[k] && !clr_err);
        m_udf[k] = (rd_en && em) || (m_udf[k] && !clr_err);
        m_rdv[k] = 0;
        if (rd_en && !em) begin
          m_rdq[k] = mq[k].pop_front();
          m_rdv[k] = 1;
        end
        if (wr_en && !fl) mq[k].push_back(wr_data);
      end
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 3; k++) begin
      int sz;
      sz = mq[k].size();
      chk("count", k, o_count[k], sz);
      chk("empty", k, o_empty[k], sz == 0);
      chk("full", k, o_full[k], sz == dep[k]);
      chk("almost_full", k, o_af[k], sz >= aft[k]);
      chk("almost_empty", k, o_ae[k], sz <= aet[k]);
      chk("overflow", k, o_ovf[k], m_ovf[k]);
      chk("underflow", k, o_udf[k], m_udf[k]);
      if (fwft[k] != 0) begin
        chk("rd_valid", k, o_rdv[k], sz != 0);
        if (sz != 0) chk("rd_data", k, o_rd_data[k], mq[k][0]);
      end else begin
        chk("rd_valid", k, o_rdv[k], m_rdv[k]);
        chk("rd_data", k, o_rd_data[k], m_rdq[k]);
      end
    end
  endtask

  task automatic step(input logic f, input logic w, input logic [7:0] d, input logic r, input logic c);
    flush = f; wr_en = w; wr_data = d; rd_en = r; clr_err = c;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 8'h00, 0, 0);
    rst = 1'b0;
  endtask

  task automatic chk_reset(input int k);
    chk("rst_count", k, o_count[k], 0);
    chk("rst_empty", k, o_empty[k], 1);
    chk("rst_full", k, o_full[k], 0);
    chk("rst_aempty", k, o_ae[k], 1);
    chk("rst_afull", k, o_af[k], 0);
    chk("rst_ovf", k, o_ovf[k], 0);
    chk("rst_udf", k, o_udf[k], 0);
    chk("rst_rdv", k, o_rdv[k], 0);
    chk("rst_rdata", k, o_rd_data[k], 0);
  endtask

  typedef struct {
    logic fl, wr; logic [7:0] wd; logic rd, clr;
    int cnt; logic emp, rdv; logic [7:0] rdd; logic udf;
  } vec_t;
  vec_t vec [12];

  initial begin
    vec[0]  = '{0, 1, 8'h11, 0, 0, 1, 0, 0, 8'h00, 0};
    vec[1]  = '{0, 1, 8'h22, 0, 0, 2, 0, 0, 8'h00, 0};
    vec[2]  = '{0, 0, 8'h00, 1, 0, 1, 0, 1, 8'h11, 0};
    vec[3]  = '{0, 1, 8'h33, 1, 0, 1, 0, 1, 8'h22, 0};
    vec[4]  = '{0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h22, 0};
    vec[5]  = '{0, 0, 8'h00, 1, 0, 0, 1, 1, 8'h33, 0};
    vec[6]  = '{0, 0, 8'h00, 1, 0, 0, 1, 0, 8'h33, 1};
    vec[7]  = '{0, 0, 8'h00, 0, 1, 0, 1, 0, 8'h33, 0};
    vec[8]  = '{0, 1, 8'h44, 1, 0, 1, 0, 0, 8'h33, 1};
    vec[9]  = '{0, 0, 8'h00, 1, 1, 0, 1, 1, 8'h44, 0};
    vec[10] = '{1, 1, 8'h55, 0, 0, 0, 1, 0, 8'h44, 0};
    vec[11] = '{0, 0, 8'h00, 1, 0, 0, 1, 0, 8'h44, 1};

    // Reset, fill to full, overflow, then reset mid-stream at count 9
    do_reset();
    for (int k = 0; k < 3; k++) chk_reset(k);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 8'(i), 0, 0);
      chk("fill_count", 0, o_count[0], i + 1);
      chk("fill_afull", 0, o_af[0], (i + 1) >= 14);
      chk("fill_full", 0, o_full[0], (i + 1) == 16);
    end
    step(0, 1, 8'h10, 0, 0);
    chk("ovf_set", 0, o_ovf[0], 1);
    chk("ovf_count", 0, o_count[0], 16);
    for (int i = 0; i < 7; i++) step(0, 0, 8'h00, 1, 0);
    chk("mid_count", 0, o_count[0], 9);
    chk("mid_ovf", 0, o_ovf[0], 1);
    rst = 1'b1;
    step(0, 1, 8'h99, 1, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) chk_reset(k);

    // Wrap on the DEPTH=5 registered FIFO
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 1, 8'h10 + 8'(i), 0, 0);
    chk("wrap_full", 1, o_full[1], 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'h00, 1, 0);
      chk("wrap_rd1", 1, o_rd_data[1], 8'h10 + 8'(i));
    end
    for (int i = 0; i < 3; i++) step(0, 1, 8'h15 + 8'(i), 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 8'h00, 1, 0);
      chk("wrap_rdv", 1, o_rdv[1], 1);
      chk("wrap_rd2", 1, o_rd_data[1], 8'h13 + 8'(i));
      step(0, 0, 8'h00, 0, 0);
      chk("wrap_rdv_pulse", 1, o_rdv[1], 0);
    end

    // FWFT latency and read-with-write at count 1
    do_reset();
    step(0, 1, 8'hA5, 0, 0);
    chk("fwft_rdv", 2, o_rdv[2], 1);
    chk("fwft_data", 2, o_rd_data[2], 8'hA5);
    step(0, 0, 8'h00, 0, 0);
    chk("fwft_hold", 2, o_rd_data[2], 8'hA5);
    step(0, 1, 8'h5A, 1, 0);
    chk("fwft_rw_rdv", 2, o_rdv[2], 1);
    chk("fwft_rw_data", 2, o_rd_data[2], 8'h5A);
    chk("fwft_rw_count", 2, o_count[2], 1);
    step(0, 0, 8'h00, 1, 0);
    chk("fwft_pop_empty", 2, o_empty[2], 1);
    chk("fwft_pop_rdv", 2, o_rdv[2], 0);

    // Simultaneous traffic at count 3, then underflow and clr_err race
    do_reset();
    for (int i = 1; i <= 3; i++) step(0, 1, 8'(i), 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 8'(4 + i), 1, 0);
      for (int k = 0; k < 3; k++) chk("simul_count", k, o_count[k], 3);
      chk("simul_rd_a", 0, o_rd_data[0], 8'(i + 1));
      chk("simul_rd_c", 2, o_rd_data[2], 8'(i + 2));
    end
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 0);
    chk("drain_last", 0, o_rd_data[0], 8'd13);
    step(0, 0, 8'h00, 1, 0);
    for (int k = 0; k < 3; k++) chk("udf_set", k, o_udf[k], 1);
    step(0, 0, 8'h00, 1, 1);
    for (int k = 0; k < 3; k++) chk("udf_set_wins", k, o_udf[k], 1);
    step(0, 0, 8'h00, 0, 1);
    for (int k = 0; k < 3; k++) chk("udf_clr", k, o_udf[k], 0);

    // Flush at count 7 with simultaneous write and read
    do_reset();
    for (int i = 0; i < 7; i++) step(0, 1, 8'h20 + 8'(i), 0, 0);
    chk("pre_flush_count", 0, o_count[0], 7);
    step(1, 1, 8'hEE, 1, 0);
    chk("flush_count", 0, o_count[0], 0);
    chk("flush_empty", 0, o_empty[0], 1);
    chk("flush_rdv", 0, o_rdv[0], 0);
    chk("flush_ovf", 0, o_ovf[0], 0);
    chk("flush_udf", 0, o_udf[0], 0);
    chk("flush_rdv_c", 2, o_rdv[2], 0);
    step(0, 1, 8'h77, 0, 0);
    chk("post_flush_fwft", 2, o_rd_data[2], 8'h77);
    step(0, 0, 8'h00, 1, 0);
    chk("post_flush_data", 0, o_rd_data[0], 8'h77);
    chk("post_flush_rdv", 0, o_rdv[0], 1);

    // Table-driven vectors against DUT A
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(vec[i].fl, vec[i].wr, vec[i].wd, vec[i].rd, vec[i].clr);
      chk($sformatf("vec%0d_count", i), 0, o_count[0], vec[i].cnt);
      chk($sformatf("vec%0d_empty", i), 0, o_empty[0], vec[i].emp);
      chk($sformatf("vec%0d_rdv", i), 0, o_rdv[0], vec[i].rdv);
      chk($sformatf("vec%0d_rdata", i), 0, o_rd_data[0], vec[i].rdd);
      chk($sformatf("vec%0d_udf", i), 0, o_udf[0], vec[i].udf);
    end

    // Randomized traffic with alternating fill/drain bias
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int wp;
      wp = ((i / 250) % 2 == 0) ? 75 : 30;
      rst = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 99) < wp,
           8'($urandom),
           $urandom_range(0, 99) < (100 - wp),
           $urandom_range(0, 29) == 0);
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
